// File: rtl/pipe_rca.sv
// Pipelined N-bit ripple-carry adder/subtractor: the carry chain is cut into STAGES
// chunks of W bits, one register stage per chunk, with a lockstep valid/ready pipeline.
module pipe_rca #(
   parameter int N      = 16,
   parameter int STAGES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] num1,
   input  logic [N-1:0] num2,
   input  logic         cin,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         ovf
);
   localparam int W = N / STAGES;

   // Stage-input bundles: entry 0 is the port side, entry k>0 is stage k-1's register.
   // Operand words are shifted right by W per stage, so a stage always adds bits [W-1:0].
   logic         v_p [STAGES];
   logic         c_p [STAGES];
   logic [N-1:0] a_p [STAGES];
   logic [N-1:0] b_p [STAGES];
   logic [N-1:0] s_p [STAGES];

   logic         en;
   logic         out_valid_q;
   logic [N-1:0] sum_q;
   logic         cout_q;
   logic         ovf_q;

   assign en       = !out_valid_q || out_ready;
   assign in_ready = en;

   assign v_p[0] = in_valid;
   assign c_p[0] = sub ? 1'b1 : cin;
   assign a_p[0] = num1;
   assign b_p[0] = sub ? ~num2 : num2;
   assign s_p[0] = '0;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         logic [W:0]   add_w;
         logic [N-1:0] s_d;

         assign add_w = {1'b0, a_p[gi][W-1:0]} + {1'b0, b_p[gi][W-1:0]} + {{W{1'b0}}, c_p[gi]};
         assign s_d   = s_p[gi] | (N'(add_w[W-1:0]) << (gi * W));

         if (gi < STAGES - 1) begin : g_mid
            logic         v_q;
            logic         c_q;
            logic [N-1:0] a_q;
            logic [N-1:0] b_q;
            logic [N-1:0] s_q;

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  v_q <= 1'b0;
                  c_q <= 1'b0;
                  a_q <= '0;
                  b_q <= '0;
                  s_q <= '0;
               end else if (en) begin
                  v_q <= v_p[gi];
                  c_q <= add_w[W];
                  a_q <= a_p[gi] >> W;
                  b_q <= b_p[gi] >> W;
                  s_q <= s_d;
               end
            end

            assign v_p[gi+1] = v_q;
            assign c_p[gi+1] = c_q;
            assign a_p[gi+1] = a_q;
            assign b_p[gi+1] = b_q;
            assign s_p[gi+1] = s_q;
         end else begin : g_last
            // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c_in.
            logic carry_msb;
            logic ovf_d;

            assign carry_msb = a_p[gi][W-1] ^ b_p[gi][W-1] ^ add_w[W-1];
            assign ovf_d     = carry_msb ^ add_w[W];

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  out_valid_q <= 1'b0;
                  sum_q       <= '0;
                  cout_q      <= 1'b0;
                  ovf_q       <= 1'b0;
               end else if (en) begin
                  out_valid_q <= v_p[gi];
                  sum_q       <= s_d;
                  cout_q      <= add_w[W];
                  ovf_q       <= ovf_d;
               end
            end
         end
      end
   endgenerate

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_rca.sv
// Self-checking bench for pipe_rca: directed table, random streaming/backpressure
// against an arithmetic reference model, and a mid-flight reset sequence.
module tb_pipe_rca;
   localparam int N      = 16;
   localparam int STAGES = 4;
   localparam longint SMAX = (longint'(1) << (N - 1)) - 1;
   localparam longint SMIN = -(longint'(1) << (N - 1));

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] num1;
   logic [N-1:0] num2;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] sum;
   logic         cout;
   logic         ovf;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [N-1:0] s;
      logic         c;
      logic         v;
   } res_t;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         ci;
      logic         sb;
      logic [N-1:0] e_sum;
      logic         e_cout;
      logic         e_ovf;
   } vec_t;

   res_t exp_q[$];
   vec_t tbl [10];

   bit   stall_prev;
   res_t snap;
   int   cyc;
   int   rx_count;
   int   acc_count;
   int   first_rx;
   int   last_rx;

   always #5 clk = ~clk;

   pipe_rca #(.N(N), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .num1      (num1),
      .num2      (num2),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   // Reference: unsigned sum for result/carry, signed sum range test for overflow.
   function automatic res_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  input logic ci, input logic sb);
      logic [N-1:0] be;
      longint       c;
      longint       u;
      longint       s;
      res_t         r;
      be  = sb ? ~b : b;
      c   = sb ? 1 : longint'(ci);
      u   = longint'(a) + longint'(be) + c;
      s   = longint'($signed(a)) + longint'($signed(be)) + c;
      r.s = u[N-1:0];
      r.c = u[N];
      r.v = (s > SMAX) || (s < SMIN);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock cycle of random traffic; inputs driven at edge+1, outputs sampled at edge+2.
   task automatic run_cycle(input bit iv, input bit ordy, input bit expect_ready);
      res_t got;
      res_t e;
      in_valid  = iv;
      num1      = N'($urandom);
      num2      = N'($urandom);
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = ordy;
      #1;
      got = '{s: sum, c: cout, v: ovf};
      if (expect_ready) check("stream_in_ready", 32'(in_ready), 32'd1);
      if (stall_prev) begin
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_hold", 32'(got), 32'(snap));
      end
      if (out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 32'd0);
      stall_prev = out_valid && !out_ready;
      snap       = got;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_out: got sum=0x%0h with no result pending", sum);
         end else begin
            e = exp_q.pop_front();
            check("result", 32'(got), 32'(e));
            $display("cyc %0d: out sum=0x%04h cout=%0b ovf=%0b", cyc, sum, cout, ovf);
         end
         rx_count++;
         if (first_rx < 0) first_rx = cyc;
         last_rx = cyc;
      end
      if (in_valid && in_ready) begin
         exp_q.push_back(model(num1, num2, cin, sub));
         acc_count++;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear_stats();
      rx_count   = 0;
      acc_count  = 0;
      first_rx   = -1;
      last_rx    = -1;
      stall_prev = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      tbl[0] = '{16'h0001, 16'h0003, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0};
      tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[2] = '{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1};
      tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      tbl[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      tbl[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
      tbl[7] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
      tbl[8] = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
      tbl[9] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

      cyc = 0;
      clear_stats();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      num1      = '0;
      num2      = '0;
      cin       = 1'b0;
      sub       = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      check("post_rst_out_valid", 32'(out_valid), 32'd0);
      check("post_rst_flags", 32'({cout, ovf}), 32'd0);

      // Directed table: one operation at a time, latency and result checked
      for (int i = 0; i < 10; i++) begin
         num1      = tbl[i].a;
         num2      = tbl[i].b;
         cin       = tbl[i].ci;
         sub       = tbl[i].sb;
         in_valid  = 1'b1;
         out_ready = 1'b1;
         #1;
         check("dir_in_ready", 32'(in_ready), 32'd1);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         lat = 0;
         while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
         end
         check("dir_latency", 32'(lat), 32'(STAGES - 1));
         check("dir_sum", 32'(sum), 32'(tbl[i].e_sum));
         check("dir_cout", 32'(cout), 32'(tbl[i].e_cout));
         check("dir_ovf", 32'(ovf), 32'(tbl[i].e_ovf));
         $display("vec %0d: 0x%04h %s 0x%04h cin=%0b -> sum=0x%04h cout=%0b ovf=%0b lat=%0d",
                  i, tbl[i].a, tbl[i].sb ? "-" : "+", tbl[i].b, tbl[i].ci, sum, cout, ovf, lat);
         @(posedge clk);
         #1;
      end

      // Streaming: 20 back-to-back operations, out_ready held high
      clear_stats();
      for (int i = 0; i < 20; i++) run_cycle(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b1, 1'b1);
      check("stream_count", 32'(rx_count), 32'd20);
      check("stream_contiguous", 32'(last_rx - first_rx + 1), 32'd20);
      check("stream_left", 32'(exp_q.size()), 32'd0);

      // Backpressure: random out_ready with a forced 5-cycle stall
      clear_stats();
      for (int i = 0; i < 40; i++) begin
         if (i >= 10 && i < 15) run_cycle(1'($urandom), 1'b0, 1'b0);
         else if (i < 10) run_cycle(1'b1, 1'($urandom), 1'b0);
         else run_cycle(1'($urandom), 1'($urandom), 1'b0);
      end
      for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b1, 1'b0);
      check("bp_count", 32'(rx_count), 32'(acc_count));
      check("bp_left", 32'(exp_q.size()), 32'd0);

      // Reset mid-flight: three operations in flight, first one stalled at the output
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         num1     = 16'h1234 + N'(i);
         num2     = 16'h1111;
         cin      = 1'b0;
         sub      = 1'b0;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("mid_pre_valid", 32'(out_valid), 32'd1);
      check("mid_pre_sum", 32'(sum), 32'h2345);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_sum", 32'(sum), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("mid_no_ghost", 32'(out_valid), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/pipe_rca.md
# pipe_rca

Parametrised, pipelined N-bit ripple-carry adder/subtractor with a valid/ready handshake on input and output. The carry chain is cut into STAGES equal chunks, one register stage per chunk. Operands are skewed so that one operation is accepted per cycle, and each result emerges after a fixed latency. It is the registered, throughput-oriented successor to the combinational N-bit RCA, for datapaths where N is too wide to ripple within one clock period.

## Interface
- N, 16, operand and result width in bits; must be divisible by STAGES
- STAGES, 4, number of pipeline stages (1..N); chunk width W = N/STAGES

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset; one clock, reset asynchronous active-low
- in_valid  input  1  operand set present
- in_ready  output  1  block can accept an operand set this cycle
- num1  input  N  operand A, unsigned or two's complement
- num2  input  N  operand B
- cin  input  1  carry-in, used when sub=0
- sub  input  1  0: A+B+cin; 1: A-B, computed as A + ~B + 1 with cin ignored
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts the result
- sum  output  N  result, modulo 2^N
- cout  output  1  carry out of bit N-1; for subtraction, 1 means no borrow
- ovf  output  1  signed overflow: carry into bit N-1 XOR carry out of bit N-1

## Operation
- Stage k (k=0..STAGES-1) adds bits [k*W +: W] of A and B_eff, using the carry registered by stage k-1. Stage 0 uses c0, where c0 = sub ? 1 : cin and B_eff = sub ? ~num2 : num2.
- Skew: upper operand chunks are delayed alongside their operation. Lower sum chunks are carried forward so that the final stage holds the complete sum.
- Each stage holds a valid bit. A global enable is defined as en = !out_valid | out_ready.
  - When en=1, every stage register loads from its predecessor.
  - Stage 0 loads {in_valid, operands}.
- in_ready = en, combinational from out_valid and out_ready.
- Bubbles are not compressed: the pipeline is a lockstep shift under en.
- ovf and cout come from the final chunk. The carry into bit N-1 is generated inside the final stage.
- When STAGES=1 the block is a single registered adder.
- Invalid stages may carry arbitrary data; only valid bits gate outputs.

## Timing
- Reset (rst_n=0, asynchronous) clears all valid bits. It also sets sum=0, cout=0 and ovf=0 and clears all datapath registers.
  - out_valid=0 while in reset and after release.
  - in_ready=1 immediately after reset.
- Reset asserted mid-operation discards every in-flight operation. No partial result appears.
- Transfer in: in_valid & in_ready at rising edge t.
  - With no stall, the result appears on sum/cout/ovf with out_valid=1 immediately after edge t+STAGES-1.
  - Latency is STAGES cycles.
- Transfer out: out_valid & out_ready at a rising edge.
- Throughput: one operation per cycle with out_ready held high.
- Stall: when out_valid=1 and out_ready=0:
  - en=0 and in_ready=0.
  - All stages, including valid bits, hold.
  - sum, cout and ovf stay stable until accepted.
  - num1, num2, cin, sub and in_valid are ignored while in_ready=0.
- Same-edge accept of output and input with en=1: the pipeline shifts and no data is lost or duplicated.
- in_valid=0 while en=1: a bubble (valid=0) enters stage 0.
- Output ordering matches input ordering. There is no reordering.

## Test plan
Parameters for all scenarios: N=16, STAGES=4.
- Reset, then single add with num1=0x0001, num2=0x0003, cin=0, sub=0 -> out_valid is high 4 cycles after acceptance with sum=0x0004, cout=0, ovf=0.
- Cross-chunk carry: num1=0xFFFF, num2=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Also num1=0x8000, num2=0x8000, cin=1 -> sum=0x0001, cout=1, ovf=1.
- Subtract: num1=0x0005, num2=0x0007, sub=1, cin=1 (cin must be ignored) -> sum=0xFFFE, cout=0, ovf=0. Also num1=0x8000, num2=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Streaming: 20 back-to-back random operations with out_ready=1 -> 20 results in order, one per cycle, each matching the reference model; in_ready remains 1.
- Backpressure: stream operations while out_ready toggles randomly and is held low for 5 consecutive cycles -> outputs stay stable during the stall and in_ready=0; no loss or duplication; order is preserved.
- Reset mid-flight: accept 3 operations, then assert rst_n=0 asynchronously between edges -> out_valid and sum drop to 0 immediately; after release, none of the 3 results ever appear.
